// File: rtl/alu_core_seq.sv
// alu_core_seq: multi-cycle ALU with a valid/ready request and result handshake.
// Logic, ADD and SUB results are produced at accept and are ready one cycle later.
// MUL runs a shift-add over WIDTH cycles and yields the full double-width product.
module alu_core_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] res_hi,
    output logic             carry,
    output logic             zero,
    output logic             err
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_next;
    logic [CW-1:0]      step;

    logic [WIDTH-1:0]   alu_res;
    logic               alu_carry;
    logic               alu_err;
    logic [WIDTH:0]     sum_ext;
    logic [WIDTH:0]     diff_ext;

    // State register; reset returns to IDLE and abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake outputs; accept only in IDLE, deliver only in DONE.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = (op == OP_MUL) ? MUL : DONE;
                end
            end
            MUL: begin
                if (step == LAST_STEP) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Single-cycle operations, evaluated on the live inputs and captured at accept.
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_err   = 1'b0;
        sum_ext   = {1'b0, a} + {1'b0, b};
        diff_ext  = {1'b0, a} - {1'b0, b};
        case (op)
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_NOT: alu_res = ~a;
            OP_ADD: begin
                alu_res   = sum_ext[WIDTH-1:0];
                alu_carry = sum_ext[WIDTH];
            end
            OP_SUB: begin
                alu_res   = diff_ext[WIDTH-1:0];
                alu_carry = diff_ext[WIDTH];
            end
            OP_MUL: alu_res = '0;
            default: alu_err = 1'b1;
        endcase
    end

    // One partial product per cycle: add the shifted multiplicand when the multiplier LSB is set.
    always_comb begin
        prod_next = prod + (mplier[0] ? mcand : '0);
    end

    // Datapath: load operands or results at accept, step the multiplier, hold results otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            step   <= '0;
            res    <= '0;
            res_hi <= '0;
            carry  <= 1'b0;
            zero   <= 1'b0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (op == OP_MUL) begin
                            mcand  <= {{WIDTH{1'b0}}, a};
                            mplier <= b;
                            prod   <= '0;
                            step   <= '0;
                        end else begin
                            res    <= alu_res;
                            res_hi <= '0;
                            carry  <= alu_carry;
                            zero   <= (alu_res == '0);
                            err    <= alu_err;
                        end
                    end
                end
                MUL: begin
                    prod   <= prod_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    step   <= step + 1'b1;
                    if (step == LAST_STEP) begin
                        res    <= prod_next[WIDTH-1:0];
                        res_hi <= prod_next[2*WIDTH-1:WIDTH];
                        carry  <= 1'b0;
                        zero   <= (prod_next == '0);
                        err    <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
